draw_chip_sprite: RTL



---
 rtl/chip_draw_pkg.sv | 28 ++
 rtl/draw_chip_sprite_if.sv | 23 ++
 rtl/chip_sprite_rom.sv | 25 ++
 rtl/draw_chip_sprite.sv | 94 +++++++++
 4 files changed

// File: rtl/chip_draw_pkg.sv
// chip_draw_pkg: shared FSM encoding, colour defaults, board geometry and chip artwork
package chip_draw_pkg;

   typedef enum logic [1:0] {ST_IDLE, ST_DRAW, ST_FLUSH, ST_DONE} draw_state_e;

   localparam logic [7:0] TRANSP_KEY_DEF = 8'h00;
   localparam logic [7:0] BG_COLOUR_DEF  = 8'hFF;

   localparam int CELL_PITCH_X = 20;
   localparam int CELL_PITCH_Y = 18;
   localparam int BOARD_COLS   = 7;
   localparam int BOARD_ROWS   = 6;

   // Round chip: dark rim, body, bright centre; corners outside the disc are transparent.
   // Works in doubled coordinates so the pixel-centre offsets stay integral.
   function automatic logic [7:0] chip_pixel(input int bank, input int row, input int col,
                                             input int w, input int h);
      int dx, dy, d2;
      dx = 2 * col + 1 - w;
      dy = 2 * row + 1 - h;
      d2 = dx * dx + dy * dy;
      if (d2 > w * h) return TRANSP_KEY_DEF;
      if (4 * d2 > 3 * w * h) return bank != 0 ? 8'h02 : 8'h80;
      if (4 * d2 <= w * h) return bank != 0 ? 8'h5F : 8'hF6;
      return bank != 0 ? 8'h03 : 8'hE0;
   endfunction

endpackage

// File: rtl/draw_chip_sprite_if.sv
// draw_chip_sprite_if: draw request and framebuffer pixel port of the chip sprite drawer
interface draw_chip_sprite_if #(
   parameter int X_W      = 8,
   parameter int Y_W      = 7,
   parameter int COLOUR_W = 8
);
   logic                start;
   logic                player;
   logic                erase;
   logic [X_W-1:0]      xin;
   logic [Y_W-1:0]      yin;
   logic [X_W-1:0]      xout;
   logic [Y_W-1:0]      yout;
   logic [COLOUR_W-1:0] colour;
   logic                plot;
   logic                busy;
   logic                done;

   modport master (output start, player, erase, xin, yin,
                   input  xout, yout, colour, plot, busy, done);
   modport slave  (input  start, player, erase, xin, yin,
                   output xout, yout, colour, plot, busy, done);
endinterface

// File: rtl/chip_sprite_rom.sv
// chip_sprite_rom: two-bank chip artwork, one-cycle synchronous read
module chip_sprite_rom
   import chip_draw_pkg::*;
#(
   parameter int SPRITE_W = 16,
   parameter int SPRITE_H = 16,
   parameter int COLOUR_W = 8,
   localparam int AW      = 1 + $clog2(SPRITE_W) + $clog2(SPRITE_H)
) (
   input  logic                clk,
   input  logic [AW-1:0]       addr_i,
   output logic [COLOUR_W-1:0] data_o
);

   logic [COLOUR_W-1:0] rom [2*SPRITE_W*SPRITE_H];

   for (genvar a = 0; a < 2 * SPRITE_W * SPRITE_H; a++) begin : g_rom
      assign rom[a] = COLOUR_W'(chip_pixel(a / (SPRITE_W * SPRITE_H), (a / SPRITE_W) % SPRITE_H,
                                           a % SPRITE_W, SPRITE_W, SPRITE_H));
   end

   // registered read gives the fixed one-cycle latency the pixel pipeline is built around
   always_ff @(posedge clk) data_o <= rom[addr_i];

endmodule

// File: rtl/draw_chip_sprite.sv
// draw_chip_sprite: rasterises one chip sprite (or erases its footprint) into a framebuffer
module draw_chip_sprite
   import chip_draw_pkg::*;
#(
   parameter int                  SPRITE_W   = 16,
   parameter int                  SPRITE_H   = 16,
   parameter int                  COLOUR_W   = 8,
   parameter int                  X_W        = 8,
   parameter int                  Y_W        = 7,
   parameter logic [COLOUR_W-1:0] TRANSP_KEY = COLOUR_W'(TRANSP_KEY_DEF),
   parameter logic [COLOUR_W-1:0] BG_COLOUR  = COLOUR_W'(BG_COLOUR_DEF)
) (
   input  logic              clk,
   input  logic              resetn,
   draw_chip_sprite_if.slave bus
);

   localparam int CW = $clog2(SPRITE_W);
   localparam int RW = $clog2(SPRITE_H);
   localparam logic [1:0] IDLE  = ST_IDLE;
   localparam logic [1:0] DRAW  = ST_DRAW;
   localparam logic [1:0] FLUSH = ST_FLUSH;
   localparam logic [1:0] DONE  = ST_DONE;

   logic [1:0]          state_q, state_d;
   logic [CW-1:0]       col_q, col_d;
   logic [RW-1:0]       row_q, row_d;
   logic [X_W-1:0]      x0_q, xout_q;
   logic [Y_W-1:0]      y0_q, yout_q;
   logic                player_q, erase_q, valid_q;
   logic [COLOUR_W-1:0] rom_data;
   logic                accept, last;

   assign accept = state_q == IDLE && bus.start;
   assign last   = &col_q && &row_q;

   // next state and raster counters; counters wrap back to 0 on the last pixel
   always_comb begin
      state_d = state_q == IDLE  ? (bus.start ? DRAW : IDLE)
              : state_q == DRAW  ? (last ? FLUSH : DRAW)
              : state_q == FLUSH ? DONE : IDLE;
      col_d   = state_q == DRAW ? col_q + 1'b1 : col_q;
      row_d   = state_q == DRAW && &col_q ? row_q + 1'b1 : row_q;
   end

   // control state, request latch and pixel coordinates aligned with the ROM output
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q  <= IDLE;
         col_q    <= '0;
         row_q    <= '0;
         x0_q     <= '0;
         y0_q     <= '0;
         player_q <= 1'b0;
         erase_q  <= 1'b0;
         xout_q   <= '0;
         yout_q   <= '0;
         valid_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         col_q   <= col_d;
         row_q   <= row_d;
         valid_q <= state_q == DRAW;
         if (accept) begin
            x0_q     <= bus.xin;
            y0_q     <= bus.yin;
            player_q <= bus.player;
            erase_q  <= bus.erase;
         end
         if (state_q == DRAW) begin
            xout_q <= x0_q + X_W'(col_q);
            yout_q <= y0_q + Y_W'(row_q);
         end
      end
   end

   chip_sprite_rom #(
      .SPRITE_W (SPRITE_W),
      .SPRITE_H (SPRITE_H),
      .COLOUR_W (COLOUR_W)
   ) u_rom (
      .clk    (clk),
      .addr_i ({player_q, row_q, col_q}),
      .data_o (rom_data)
   );

   assign bus.xout   = xout_q;
   assign bus.yout   = yout_q;
   assign bus.plot   = valid_q && (erase_q || rom_data != TRANSP_KEY);
   assign bus.colour = !valid_q ? '0 : erase_q ? BG_COLOUR : rom_data;
   assign bus.busy   = state_q != IDLE;
   assign bus.done   = state_q == DONE;

endmodule
